word_serializer: RTL and testbench



---
 rtl/word_serializer_if.sv | 37 +++
 rtl/word_serializer.sv | 100 ++++++++++
 tb/tb_word_serializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/word_serializer_if.sv
// Handshake bundle between a single-word source buffer, the word serializer
// and the chunk consumer. The slave modport is the serializer's view.
interface word_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2
);
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_clear;
  logic                  step;
  logic                  out_valid;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  in_empty,
    input  in_data,
    input  step,
    output in_clear,
    output out_valid,
    output out_data,
    output out_last,
    output busy
  );

  modport master (
    output in_empty,
    output in_data,
    output step,
    input  in_clear,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  busy
  );
endinterface

// File: rtl/word_serializer.sv
// Word serializer: takes one word from a single-word buffer and emits it as
// DATA_WIDTH/OUT_WIDTH chunks, one chunk retired per step pulse. When the next
// word is already buffered at the final step it is reloaded with no gap.
// Build option WORD_SERIALIZER_MSB_FIRST_EN: emit most-significant chunk first
// (default is LSB-first). Timing and handshake are the same in both builds.
//
// state   | meaning
// S_IDLE  | no word held; waiting for the buffer to become non-empty
// S_SHIFT | word held; out_data is valid, chunk idx_q is being presented
module word_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  word_serializer_if.slave    bus
);

  localparam int NCHUNK = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  load;

  // State register: FSM state, shift register and chunk index
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: load, shift, reload-on-last-step or return to idle
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.in_empty) begin
          load    = 1'b1;
          sr_d    = bus.in_data;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.step) begin
          if (idx_q != LAST_IDX) begin
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
            sr_d = sr_q << OUT_WIDTH;
`else
            sr_d = sr_q >> OUT_WIDTH;
`endif
            idx_d = idx_q + IDX_W'(1);
          end else if (!bus.in_empty) begin
            load  = 1'b1;
            sr_d  = bus.in_data;
            idx_d = '0;
          end else begin
            // clearing sr keeps out_data at zero whenever nothing is valid
            state_d = S_IDLE;
            sr_d    = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sr_d    = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs: in_clear and out_last are combinational, the rest come from flops
  always_comb begin
    bus.in_clear  = load && !reset;
    bus.out_valid = (state_q == S_SHIFT);
    bus.busy      = (state_q == S_SHIFT);
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
    bus.out_data  = sr_q[DATA_WIDTH-1 -: OUT_WIDTH];
`else
    bus.out_data  = sr_q[OUT_WIDTH-1:0];
`endif
    bus.out_last  = (state_q == S_SHIFT) && (idx_q == LAST_IDX);
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus randomized
// traffic, compared every cycle against a word/chunk-count reference model
// fed by a behavioural single-word buffer.
module tb_word_serializer;
  localparam int DW = 8;
  localparam int OW = 2;
  localparam int NC = DW / OW;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  word_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  word_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: buffer contents, current word, chunks still to retire
  logic          buf_full;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] cur_word;
  int            remaining;
  logic [OW-1:0] retired[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] chunk_of(input logic [DW-1:0] w, input int k);
    logic [DW-1:0] t;
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
    t = w >> (DW - OW * (k + 1));
`else
    t = w >> (OW * k);
`endif
    return t[OW-1:0];
  endfunction

  // one clock cycle: drive inputs, check at negedge, advance model at posedge
  task automatic tick(input logic r, input logic s, input logic wr, input logic [DW-1:0] wd);
    logic          e_clear;
    logic          e_valid;
    logic [OW-1:0] e_data;
    logic          e_last;
    reset        = r;
    bus.step     = s;
    bus.in_empty = !buf_full;
    bus.in_data  = buf_full ? buf_data : DW'($urandom);
    @(negedge clk);
    e_valid = (remaining > 0);
    e_data  = e_valid ? chunk_of(cur_word, NC - remaining) : '0;
    e_last  = (remaining == 1);
    e_clear = !r && buf_full && (remaining == 0 || (s && remaining == 1));
    chk("in_clear", 32'(bus.in_clear), 32'(e_clear));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("busy", 32'(bus.busy), 32'(e_valid));
    chk("out_data", 32'(bus.out_data), 32'(e_data));
    chk("out_last", 32'(bus.out_last), 32'(e_last));
    if (!r && s && bus.out_valid) retired.push_back(bus.out_data);
    if (r) begin
      remaining = 0;
    end else if (e_clear) begin
      cur_word  = buf_data;
      remaining = NC;
      buf_full  = 1'b0;
    end else if (s && remaining > 0) begin
      remaining--;
    end
    if (wr && !buf_full) begin
      buf_full = 1'b1;
      buf_data = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stream(input string tag, input logic [OW-1:0] exp[$]);
    chk({tag, "_len"}, 32'(retired.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < retired.size(); i++)
      chk(tag, 32'(retired[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [OW-1:0] exp_q[$];
    checks    = 0;
    failures  = 0;
    buf_full  = 1'b0;
    buf_data  = '0;
    cur_word  = '0;
    remaining = 0;
    reset     = 1'b1;
    bus.step  = 1'b0;
    bus.in_empty = 1'b1;
    bus.in_data  = '0;

    // reset with step toggling, then idle with an empty buffer
    for (int i = 0; i < 4; i++) tick(1'b1, 1'(i % 2), 1'b0, '0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'(i % 2), 1'b0, '0);

    // 0xB4, step every 4th cycle
    retired.delete();
    tick(1'b0, 1'b0, 1'b1, 8'hB4);
    for (int i = 0; i < 18; i++) tick(1'b0, 1'(i % 4 == 3), 1'b0, '0);
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
    exp_q = '{2'd2, 2'd3, 2'd1, 2'd0};
`else
    exp_q = '{2'd0, 2'd1, 2'd3, 2'd2};
`endif
    chk_stream("b4_stream", exp_q);

    // 0xB4 then 0x1E buffered before the final step: seamless reload
    retired.delete();
    tick(1'b0, 1'b0, 1'b1, 8'hB4);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'(i % 4 == 3), 1'(i == 10), 8'h1E);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, '0);
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
    exp_q = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
`else
    exp_q = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
`endif
    chk_stream("b2b_stream", exp_q);

    // step tied high, 0xFF: four chunks of 3 then idle
    retired.delete();
    tick(1'b0, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b0, '0);
    exp_q = '{2'd3, 2'd3, 2'd3, 2'd3};
    chk_stream("ff_stream", exp_q);

    // reset after the second chunk: partial word discarded, no in_clear
    tick(1'b0, 1'b0, 1'b1, 8'hB4);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'(i % 2), 1'b0, '0);

    // randomized traffic
    for (int i = 0; i < 2500; i++)
      tick(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) == 0), DW'($urandom));
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
